// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: pin synchronisers, 11-bit frame deframer with
// parity/stop/timeout checks, E0/F0 prefix decode and a decoded-code FIFO.
module ps2_rx_fifo #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             ps2_clock,
  input  logic                             ps2_data,
  output logic [7:0]                       code_out,
  output logic                             extended_out,
  output logic                             release_out,
  output logic                             code_valid,
  input  logic                             code_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count,
  output logic                             parity_error,
  output logic                             frame_error,
  output logic                             overflow
);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic                   clk_prev, fall, bit_in;

  // Idle bus level is high, so the chains reset to 1 to avoid a false edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
      fall     <= 1'b0;
      bit_in   <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clock};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev <= clk_sync[SYNC_STAGES-1];
      fall     <= clk_prev & ~clk_sync[SYNC_STAGES-1];
      bit_in   <= dat_sync[SYNC_STAGES-1];
    end
  end

  state_t        state;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] tcount;
  logic          e0, f0;
  logic          parity_ok, push;
  logic [9:0]    push_word;

  assign parity_ok = ^{shreg, par_bit};
  assign push      = (state == STOP) && fall && bit_in && parity_ok &&
                     (shreg != 8'hE0) && (shreg != 8'hF0);
  assign push_word = {e0, f0, shreg};

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      bit_idx      <= '0;
      shreg        <= '0;
      par_bit      <= 1'b0;
      tcount       <= '0;
      e0           <= 1'b0;
      f0           <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
      if (state == IDLE) begin
        tcount <= '0;
        if (fall && !bit_in) begin
          state   <= DATA;
          bit_idx <= '0;
        end
      end else if (fall) begin
        tcount <= '0;
        case (state)
          DATA: begin
            shreg   <= {bit_in, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_bit <= bit_in;
            state   <= STOP;
          end
          STOP: begin
            state        <= IDLE;
            parity_error <= !parity_ok;
            frame_error  <= !bit_in;
            if (!parity_ok || !bit_in) begin
              e0 <= 1'b0;
              f0 <= 1'b0;
            end else if (shreg == 8'hE0) begin
              e0 <= 1'b1;
            end else if (shreg == 8'hF0) begin
              f0 <= 1'b1;
            end else begin
              e0 <= 1'b0;
              f0 <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (tcount == TW'(TIMEOUT_CYCLES-1)) begin
        // Stalled partial frame: abort and drop any pending prefix.
        frame_error <= 1'b1;
        state       <= IDLE;
        tcount      <= '0;
        e0          <= 1'b0;
        f0          <= 1'b0;
      end else begin
        tcount <= tcount + TW'(1);
      end
    end
  end

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          full, pop, do_push;

  assign code_valid = (fifo_count != '0);
  assign full       = (fifo_count == CW'(FIFO_DEPTH));
  assign pop        = code_valid && code_ready;
  assign do_push    = push && (!full || pop);

  // Gated by code_valid so the head reads zero whenever the FIFO is empty.
  assign code_out     = code_valid ? mem[rd_ptr][7:0] : 8'h00;
  assign release_out  = code_valid ? mem[rd_ptr][8]   : 1'b0;
  assign extended_out = code_valid ? mem[rd_ptr][9]   : 1'b0;

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      overflow <= push && full && !pop;
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end
endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
- System-clock-synchronous PS/2 keyboard receiver. Generalised successor to the original PS/2 input path.
- Oversamples the raw PS/2 clock and data pins and deframes 11-bit frames, checking parity, stop bit and timeout.
- Decodes E0 (extended) and F0 (break) prefixes.
- Buffers decoded codes in a parametrised FIFO with a valid/ready output handshake. Display and game logic consume it in the `clock` domain.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flip-flops on ps2_clock and ps2_data (minimum 2).
- TIMEOUT_CYCLES, 50000, system cycles without a PS/2 falling edge before a partial frame is aborted.
- FIFO_DEPTH, 8, number of decoded-code entries (power of two, minimum 2).

Ports:
- clock  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- ps2_clock  input  1  raw PS/2 clock pin (asynchronous).
- ps2_data  input  1  raw PS/2 data pin (asynchronous).
- code_out  output  8  scan code at the FIFO head.
- extended_out  output  1  head code was preceded by E0.
- release_out  output  1  head code was preceded by F0 (key released).
- code_valid  output  1  FIFO not empty.
- code_ready  input  1  consumer accepts the head when code_valid is high.
- fifo_count  output  $clog2(FIFO_DEPTH+1)  number of occupied entries.
- parity_error  output  1  one-cycle pulse when a frame fails odd parity.
- frame_error  output  1  one-cycle pulse on a bad stop bit or a timeout.
- overflow  output  1  one-cycle pulse when a code is dropped because the FIFO is full.

Behaviour:
- Reset values:
  - all outputs 0; code_out 8'h00; fifo_count 0;
  - FSM in IDLE; E0/F0 flags clear; FIFO empty;
  - synchronisers loaded with 1 (the idle bus level).
- Sampling:
  - Both pins pass through SYNC_STAGES flops.
  - A falling edge is the previous synced clock = 1 and the current synced clock = 0. It lasts one cycle. Data is sampled in that cycle.
- FSM states and transitions, on a falling edge:
  - IDLE: data 0 -> DATA with bit index 0. Data 1 -> stay in IDLE, no error.
  - DATA: shift data in LSB first. After bit index 7 -> PARITY.
  - PARITY: capture the parity bit -> STOP.
  - STOP: the frame is good if the stop bit is 1 and XOR(8 data bits, parity bit) = 1. Go to IDLE in all cases.
- Errors at STOP:
  - Bad parity pulses parity_error.
  - Stop bit 0 pulses frame_error.
  - If both are bad, pulse both.
  - An errored frame pushes nothing and clears the E0/F0 flags.
- Timeout:
  - The counter runs in DATA, PARITY and STOP and resets on every falling edge.
  - When it reaches TIMEOUT_CYCLES: pulse frame_error, return to IDLE, clear the flags, push nothing.
  - No timeout applies in IDLE.
- Decode of a good byte:
  - 8'hE0: set the E0 flag, no push.
  - 8'hF0: set the F0 flag, no push.
  - Any other byte: push {E0 flag, F0 flag, byte}, then clear both flags.
  - A repeated prefix keeps its flag set.
- Latency:
  - The push happens in the cycle the stop-bit edge is detected (cycle N).
  - code_valid and the new fifo_count are visible in cycle N+1.
  - From the raw pin edge this is SYNC_STAGES+2 cycles.
- FIFO:
  - Width 10; read pointer and write pointer wrap modulo FIFO_DEPTH.
  - Pop when code_valid && code_ready. code_out, extended_out and release_out show the head combinationally from storage.
  - Push while full and no pop in the same cycle: the code is dropped, overflow pulses, contents are unchanged.
  - Push and pop in the same cycle while full: both happen; fifo_count stays at FIFO_DEPTH; no overflow.
  - Push while empty: no same-cycle pop, because code_valid is still low.
- Mid-operation and parity cases:
  - Reset asserted mid-frame or with a non-empty FIFO returns everything to the reset values on the next edge. The partial frame is discarded.
  - A parity-error pulse and a pop can occur in the same cycle independently.

Test Plan:
1. Bench PS/2 clock period 100 system cycles. Send frame 0x1C (parity 0, stop 1) -> one entry {0,0,1C}; code_valid rises SYNC_STAGES+2 cycles after the stop edge; code_ready=1 pops it and fifo_count returns 0.
2. Sequence E0 75, E0 F0 75, 1C with code_ready=0 -> fifo_count 2 after the two E0 frames; the final 1C then gives fifo_count 3. Entries are {1,0,75}, {1,1,75}, {0,0,1C}, in order.
3. 0x1C with parity 1 -> parity_error pulses exactly once, fifo_count stays 0. A following good 0x1C is queued correctly.
4. Start bit plus 4 data bits, then the clock held high -> frame_error pulses after TIMEOUT_CYCLES (test value 500), state returns to IDLE. A following full 0x29 frame decodes to {0,0,29}.
5. FIFO_DEPTH=4, code_ready=0, send 5 codes 0x01..0x05 -> fifo_count 4, overflow pulses once on the fifth, head is 0x01. With code_ready=1 and a push on the same cycle as a pop while full, fifo_count stays 4 and there is no overflow.
6. Assert reset after 6 bits of a frame and with 2 entries queued -> after one cycle all outputs are 0 and the FIFO is empty. A good 0x5A frame afterwards gives {0,0,5A}. Stop bit 0 on a frame -> frame_error pulses, no push.
